flash_spi_reader: RTL and testbench
===================================

Name: flash_spi_reader

Overview:
- Serial flash engine downstream of the flash cache/buffer controller. Consumes the buffer's qspi_* request interface and drives the external flash pins on io0/io1.
- Issues a wake-up command after reset, then reads 32-bit little-endian words from any 24-bit address.
- Keeps CS low between words for sequential streaming; the address auto-increments.

Parameters:
- SCK_DIV, 1: SCK half-period in clk cycles (≥1).
- CSB_HIGH_CYCLES, 4: minimum CSB-high time between transactions, in clk cycles.
- STARTUP_CYCLES, 64: wait before the wake command and again after it (tRES), in clk cycles.

Ports:
- clk  in  1  system clock (wb_clk_i domain)
- rst_n  in  1  asynchronous active-low reset
- qspi_enable  in  1  engine enable; low forces CSB high and goes to IDLE
- qspi_address  in  24  byte address, sampled with qspi_changeAddress
- qspi_changeAddress  in  1  start a new read transaction at qspi_address
- qspi_requestData  in  1  fetch the next 32-bit word
- qspi_readData  out  32  last word read; byte at lowest address in [7:0]
- qspi_readDataValid  out  1  one-cycle pulse when qspi_readData updates
- qspi_initialised  out  1  wake sequence complete (sticky until reset)
- qspi_busy  out  1  engine cannot accept a request
- flash_csb  out  1  chip select, active low
- flash_sck  out  1  serial clock, mode 0
- flash_io0_we / flash_io0_write / flash_io0_read  out/out/in  1  io0 pad control (MOSI)
- flash_io1_we / flash_io1_write / flash_io1_read  out/out/in  1  io1 pad control (MISO)

Behaviour:
- Reset values (async, immediate, including mid-transfer):
  - flash_csb=1, flash_sck=0.
  - io0_we=0, io1_we=0, io*_write=0.
  - readData=0, readDataValid=0, initialised=0, busy=1.
  - State STARTUP.
- SPI mode 0:
  - SCK idles low and toggles every SCK_DIV clk cycles.
  - io0_write changes on the clk edge that drops SCK.
  - Sampling happens on the clk edge that raises SCK.
  - Data is MSB-first within each byte.
  - io0_we=1 while CSB is low in command/address phases, 0 otherwise.
  - io1_we=0 always, except where the optional feature states otherwise.
- States:
  - STARTUP: wait STARTUP_CYCLES, then shift 0xAB with CSB low, raise CSB, wait STARTUP_CYCLES. Then set initialised=1 and go to IDLE. This sequence runs regardless of qspi_enable.
  - IDLE: CSB=1, busy=0.
  - CSB_GAP: CSB=1 for CSB_HIGH_CYCLES, busy=1, then go to COMMAND.
  - COMMAND: shift 0x03 followed by address[23:0], 32 SCK periods, then go to READ.
  - READ: sample 32 bits (4 bytes, MSB-first each). Bytes are placed at [7:0], [15:8], [23:16], [31:24] in arrival order.
    - readData and readDataValid update one cycle after the 32nd sampling edge.
    - Internal address advances by 4 (24-bit wrap, 0xFFFFFC→0x000000).
    - Then go to HOLD.
  - HOLD: CSB stays low, SCK low, busy=0.
- busy=0 only in IDLE and HOLD; requests are sampled only when busy=0 and qspi_enable=1. Requests made while busy=1 are ignored.
- In IDLE:
  - changeAddress → latch address, go to CSB_GAP.
  - requestData alone → rejected, no transaction. The current address is invalid until the first changeAddress.
- In HOLD:
  - requestData → go to READ (next sequential word, no command phase).
  - changeAddress → raise CSB, go to CSB_GAP.
- changeAddress and requestData in the same cycle: changeAddress wins, and exactly one word from the new address is then read automatically.
- qspi_enable low in any state except STARTUP → CSB=1, SCK=0, go to IDLE next cycle. A partial word is discarded with no valid pulse.
- Latency, SCK_DIV=1, changeAddress accepted at cycle 0: CSB low at cycle 1+CSB_HIGH_CYCLES. readDataValid follows 128 cycles after CSB falls (32-bit command + 32-bit read).

Optional Feature:
- Macro FLASH_DUAL_READ_EN.
- Defined:
  - Command is 0x3B, followed by 24-bit address and 8 dummy SCK periods (io0_we=0).
  - Read phase samples io1 as the even bit and io0 as the odd bit per SCK, MSB first. A word takes 16 SCK periods.
  - io0_we=0 during dummy and read phases.
- Undefined: single-bit 0x03 read as described above; io0_read is unused.

Decomposition:
- Shared package flash_pkg:
  - state enum.
  - Command constants CMD_READ=0x03, CMD_DUAL_READ=0x3B, CMD_WAKE=0xAB.
  - FLASH_ADDR_W=24, FLASH_WORD_W=32.
- Sub-module flash_spi_shifter:
  - SCK divider plus bit counter and shift register.
  - Signals: start, bit count, tx data, done, rx data, rise/fall strobes.
  - The FSM owns only sequencing and byte reorder.

Test Plan:
- Reset release → CSB falls at cycle 65, 0xAB shifted on io0, CSB rises. initialised=1 and busy=0 after the second 64-cycle wait.
- changeAddress with address 0x000100 plus requestData; flash model returns bytes 11 22 33 44 → io0 carries 0x03000100. readData=0x44332211, valid pulse exactly 1 cycle, CSB stays low.
- Three further requestData in HOLD → no command phase, words from 0x104/0x108/0x10C. Each valid pulse arrives 64 cycles after acceptance.
- changeAddress 0xFFFFFC, then two requestData → CSB gap ≥4 cycles. Second word comes from address 0x000000 (model wraps).
- qspi_enable dropped mid-READ → CSB=1 next cycle, no valid pulse. A later request returns to IDLE behaviour, and requestData without changeAddress is ignored.
- rst_n asserted mid-COMMAND → CSB=1, SCK=0 asynchronously and initialised=0. The startup sequence then repeats.
- Built with FLASH_DUAL_READ_EN: 0x3B, 8 dummy cycles, 16 SCK per word, same readData value as the single-bit test.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared constants, state encoding and helpers for the serial flash read engine.
package flash_pkg;

  localparam int FLASH_ADDR_W = 24;
  localparam int FLASH_WORD_W = 32;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_DUAL_READ = 8'h3B;
  localparam logic [7:0] CMD_WAKE      = 8'hAB;

  typedef logic [3:0] state_t;

  localparam state_t ST_STARTUP = 4'd0;
  localparam state_t ST_WAKE    = 4'd1;
  localparam state_t ST_TRES    = 4'd2;
  localparam state_t ST_IDLE    = 4'd3;
  localparam state_t ST_CSB_GAP = 4'd4;
  localparam state_t ST_COMMAND = 4'd5;
  localparam state_t ST_DUMMY   = 4'd6;
  localparam state_t ST_READ    = 4'd7;
  localparam state_t ST_HOLD    = 4'd8;

  // First byte off the wire lands in [7:0].
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/flash_spi_shifter.sv
// Mode-0 SCK generator with SCK-period counter and MSB-first shift registers.
// Output bits change on falling SCK; input bits are captured on rising SCK.
module flash_spi_shifter #(
  parameter int SCK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [4:0]  i_count,
  input  logic [31:0] i_tx,
  input  logic        i_dual,
  input  logic        i_io0,
  input  logic        i_io1,
  output logic        o_done,
  output logic [31:0] o_rx,
  output logic        o_sck,
  output logic        o_mosi
);

  localparam logic [15:0] DIV_RELOAD = 16'(SCK_DIV - 1);

  logic        r_active;
  logic        r_sck;
  logic        r_mosi;
  logic [15:0] r_div;
  logic [4:0]  r_bits;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic        w_tick;
  logic        w_rise;
  logic        w_fall;

  assign w_tick = r_active && (r_div == '0);
  assign w_rise = w_tick && !r_sck;
  assign w_fall = w_tick && r_sck;
  assign o_done = w_fall && (r_bits == '0);
  assign o_rx   = r_rx;
  assign o_sck  = r_sck;
  assign o_mosi = r_mosi;

  // i_count holds SCK periods minus one; r_tx is kept pre-shifted so the
  // next outgoing bit is always r_tx[31].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_sck    <= 1'b0;
      r_mosi   <= 1'b0;
      r_div    <= '0;
      r_bits   <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
    end else if (i_abort) begin
      r_active <= 1'b0;
      r_sck    <= 1'b0;
      r_mosi   <= 1'b0;
      r_div    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_sck    <= 1'b0;
      r_div    <= DIV_RELOAD;
      r_bits   <= i_count;
      r_mosi   <= i_tx[31];
      r_tx     <= {i_tx[30:0], 1'b0};
    end else if (w_tick) begin
      r_sck <= !r_sck;
      r_div <= DIV_RELOAD;
      if (w_rise) begin
        r_rx <= i_dual ? {r_rx[29:0], i_io1, i_io0} : {r_rx[30:0], i_io1};
      end else begin
        r_mosi <= r_tx[31];
        r_tx   <= {r_tx[30:0], 1'b0};
        if (r_bits == '0) r_active <= 1'b0;
        else              r_bits   <= r_bits - 5'd1;
      end
    end else if (r_active) begin
      r_div <= r_div - 16'd1;
    end
  end

endmodule

// File: rtl/flash_spi_reader.sv
// Serial flash read engine: wake-up after reset, then streamed 32-bit little-endian reads.
// Define FLASH_DUAL_READ_EN for 0x3B dual-output reads (8 dummy SCKs, 16 SCKs per word).
//
// state      | meaning
// STARTUP    | power-up wait before the wake command
// WAKE       | shifting 0xAB with CSB low
// TRES       | post-wake wait, then initialised
// IDLE       | CSB high, waiting for a new address
// CSB_GAP    | enforced CSB-high time before a command
// COMMAND    | shifting read opcode and 24-bit address
// DUMMY      | dummy SCKs (dual build only)
// READ       | capturing one 32-bit word
// HOLD       | CSB low, SCK parked, ready for the next sequential word
module flash_spi_reader
  import flash_pkg::*;
#(
  parameter int SCK_DIV         = 1,
  parameter int CSB_HIGH_CYCLES = 4,
  parameter int STARTUP_CYCLES  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    qspi_enable,
  input  logic [FLASH_ADDR_W-1:0] qspi_address,
  input  logic                    qspi_changeAddress,
  input  logic                    qspi_requestData,
  output logic [FLASH_WORD_W-1:0] qspi_readData,
  output logic                    qspi_readDataValid,
  output logic                    qspi_initialised,
  output logic                    qspi_busy,
  output logic                    flash_csb,
  output logic                    flash_sck,
  output logic                    flash_io0_we,
  output logic                    flash_io0_write,
  input  logic                    flash_io0_read,
  output logic                    flash_io1_we,
  output logic                    flash_io1_write,
  input  logic                    flash_io1_read
);

  localparam logic [15:0] STARTUP_M1 = 16'(STARTUP_CYCLES - 1);
  localparam logic [15:0] GAP_M1     = 16'(CSB_HIGH_CYCLES - 1);

`ifdef FLASH_DUAL_READ_EN
  localparam logic [7:0] READ_CMD     = CMD_DUAL_READ;
  localparam logic [4:0] READ_SCKS_M1 = 5'd15;
  localparam bit         DUAL         = 1'b1;
`else
  localparam logic [7:0] READ_CMD     = CMD_READ;
  localparam logic [4:0] READ_SCKS_M1 = 5'd31;
  localparam bit         DUAL         = 1'b0;
  logic w_unused_io0;
  assign w_unused_io0 = flash_io0_read;
`endif

  state_t                  r_state;
  logic [15:0]             r_timer;
  logic                    r_csb;
  logic [FLASH_ADDR_W-1:0] r_addr;
  logic [FLASH_WORD_W-1:0] r_read_data;
  logic                    r_valid;
  logic                    r_init;

  logic        w_start;
  logic        w_abort;
  logic        w_done;
  logic        w_dual;
  logic        w_in_startup;
  logic [4:0]  w_count;
  logic [31:0] w_tx;
  logic [31:0] w_rx;

  assign w_in_startup = (r_state == ST_STARTUP) || (r_state == ST_WAKE) || (r_state == ST_TRES);
  assign w_abort      = !qspi_enable && !w_in_startup;
  assign w_dual       = DUAL && (r_state == ST_READ);

  // Each phase launches the next transfer on the same edge the previous one finishes.
  always_comb begin
    w_start = 1'b0;
    w_count = READ_SCKS_M1;
    w_tx    = '0;
    case (r_state)
      ST_STARTUP: if (r_timer == '0) begin
        w_start = 1'b1;
        w_count = 5'd7;
        w_tx    = {CMD_WAKE, 24'h0};
      end
      ST_CSB_GAP: if (r_timer == '0) begin
        w_start = 1'b1;
        w_count = 5'd31;
        w_tx    = {READ_CMD, r_addr};
      end
      ST_COMMAND: if (w_done) begin
        w_start = 1'b1;
        w_count = DUAL ? 5'd7 : READ_SCKS_M1;
      end
      ST_DUMMY:   w_start = w_done;
      ST_HOLD:    w_start = !qspi_changeAddress && qspi_requestData;
      default:    w_start = 1'b0;
    endcase
  end

  flash_spi_shifter #(.SCK_DIV(SCK_DIV)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_abort (w_abort),
    .i_count (w_count),
    .i_tx    (w_tx),
    .i_dual  (w_dual),
    .i_io0   (flash_io0_read),
    .i_io1   (flash_io1_read),
    .o_done  (w_done),
    .o_rx    (w_rx),
    .o_sck   (flash_sck),
    .o_mosi  (flash_io0_write)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_STARTUP;
      r_timer     <= STARTUP_M1;
      r_csb       <= 1'b1;
      r_addr      <= '0;
      r_read_data <= '0;
      r_valid     <= 1'b0;
      r_init      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_abort) begin
        r_state <= ST_IDLE;
        r_csb   <= 1'b1;
      end else begin
        case (r_state)
          ST_STARTUP: if (r_timer == '0) begin
            r_state <= ST_WAKE;
            r_csb   <= 1'b0;
          end else r_timer <= r_timer - 16'd1;
          ST_WAKE: if (w_done) begin
            r_state <= ST_TRES;
            r_csb   <= 1'b1;
            r_timer <= STARTUP_M1;
          end
          ST_TRES: if (r_timer == '0) begin
            r_state <= ST_IDLE;
            r_init  <= 1'b1;
          end else r_timer <= r_timer - 16'd1;
          ST_IDLE: if (qspi_changeAddress) begin
            r_state <= ST_CSB_GAP;
            r_addr  <= qspi_address;
            r_timer <= GAP_M1;
          end
          ST_CSB_GAP: if (r_timer == '0) begin
            r_state <= ST_COMMAND;
            r_csb   <= 1'b0;
          end else r_timer <= r_timer - 16'd1;
          ST_COMMAND: if (w_done) r_state <= DUAL ? ST_DUMMY : ST_READ;
          ST_DUMMY:   if (w_done) r_state <= ST_READ;
          ST_READ: if (w_done) begin
            r_state     <= ST_HOLD;
            r_read_data <= byte_swap(w_rx);
            r_valid     <= 1'b1;
            r_addr      <= r_addr + 24'd4;
          end
          ST_HOLD: if (qspi_changeAddress) begin
            r_state <= ST_CSB_GAP;
            r_csb   <= 1'b1;
            r_addr  <= qspi_address;
            r_timer <= GAP_M1;
          end else if (qspi_requestData) begin
            r_state <= ST_READ;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign qspi_readData      = r_read_data;
  assign qspi_readDataValid = r_valid;
  assign qspi_initialised   = r_init;
  assign qspi_busy          = !((r_state == ST_IDLE) || (r_state == ST_HOLD));
  assign flash_csb          = r_csb;
  assign flash_io0_we       = (r_state == ST_WAKE) || (r_state == ST_COMMAND);
  assign flash_io1_we       = 1'b0;
  assign flash_io1_write    = 1'b0;

endmodule

// File: tb/tb_flash_spi_reader.sv
// Directed bench for flash_spi_reader (default single-bit build) with a small serial flash model.
module tb_flash_spi_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        qspi_enable;
  logic [23:0] qspi_address;
  logic        qspi_changeAddress;
  logic        qspi_requestData;
  logic [31:0] qspi_readData;
  logic        qspi_readDataValid;
  logic        qspi_initialised;
  logic        qspi_busy;
  logic        flash_csb;
  logic        flash_sck;
  logic        flash_io0_we;
  logic        flash_io0_write;
  logic        flash_io0_read = 1'b0;
  logic        flash_io1_we;
  logic        flash_io1_write;
  logic        m_io1 = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  flash_spi_reader dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .qspi_enable        (qspi_enable),
    .qspi_address       (qspi_address),
    .qspi_changeAddress (qspi_changeAddress),
    .qspi_requestData   (qspi_requestData),
    .qspi_readData      (qspi_readData),
    .qspi_readDataValid (qspi_readDataValid),
    .qspi_initialised   (qspi_initialised),
    .qspi_busy          (qspi_busy),
    .flash_csb          (flash_csb),
    .flash_sck          (flash_sck),
    .flash_io0_we       (flash_io0_we),
    .flash_io0_write    (flash_io0_write),
    .flash_io0_read     (flash_io0_read),
    .flash_io1_we       (flash_io1_we),
    .flash_io1_write    (flash_io1_write),
    .flash_io1_read     (m_io1)
  );

  // Flash model: captures the first 32 bits after CSB falls, then streams bytes on io1.
  logic [31:0] m_cmd = '0;
  logic [23:0] m_base = '0;
  logic [23:0] m_addr;
  logic [7:0]  m_byte;
  int          m_rises = 0;
  int          m_csb_falls = 0;
  int          m_k;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [7:0] b;
    b = ({6'd0, a[1:0]} + 8'd1) * 8'h11;
    return b ^ {a[7:2], 2'b00} ^ a[23:16];
  endfunction

  always @(negedge flash_csb) begin
    m_rises = 0;
    m_cmd = '0;
    m_csb_falls++;
  end

  always @(posedge flash_sck) begin
    if (!flash_csb) begin
      if (m_rises < 32) m_cmd = {m_cmd[30:0], flash_io0_write};
      m_rises++;
      if (m_rises == 32) m_base = m_cmd[23:0];
    end
  end

  always @(negedge flash_sck) begin
    if (!flash_csb && m_rises >= 32) begin
      m_k    = m_rises - 32;
      m_addr = m_base + 24'(m_k / 8);
      m_byte = mem_byte(m_addr);
      m_io1  = m_byte[7 - (m_k % 8)];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!qspi_readDataValid && cyc < limit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int falls0;
    int pulses;

    rst_n = 1'b0;
    qspi_enable = 1'b1;
    qspi_address = '0;
    qspi_changeAddress = 1'b0;
    qspi_requestData = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_csb", flash_csb, 1);
    chk("rst_sck", flash_sck, 0);
    chk("rst_io0_we", flash_io0_we, 0);
    chk("rst_io1_we", flash_io1_we, 0);
    chk("rst_init", qspi_initialised, 0);
    chk("rst_busy", qspi_busy, 1);
    chk("rst_data", qspi_readData, 32'h0);
    chk("rst_valid", qspi_readDataValid, 0);

    // Startup: CSB falls on the 64th edge after release, wake is 8 SCKs, then 64 more.
    rst_n = 1'b1;
    repeat (63) @(negedge clk);
    chk("startup_csb_high", flash_csb, 1);
    @(negedge clk);
    chk("wake_csb_low", flash_csb, 0);
    chk("wake_io0_we", flash_io0_we, 1);
    n = 0;
    while (flash_csb == 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wake_len", n, 16);
    chk("wake_cmd", {24'h0, m_cmd[7:0]}, 32'hAB);
    chk("wake_bits", m_rises, 8);
    repeat (63) @(negedge clk);
    chk("tres_init_low", qspi_initialised, 0);
    @(negedge clk);
    chk("init_high", qspi_initialised, 1);
    chk("init_busy", qspi_busy, 0);

    // First word: changeAddress + requestData together reads exactly one word.
    qspi_address = 24'h000100;
    qspi_changeAddress = 1'b1;
    qspi_requestData = 1'b1;
    @(negedge clk);
    qspi_changeAddress = 1'b0;
    qspi_requestData = 1'b0;
    chk("gap_busy", qspi_busy, 1);
    repeat (3) @(negedge clk);
    chk("gap_csb_high", flash_csb, 1);
    @(negedge clk);
    chk("cmd_csb_low", flash_csb, 0);
    chk("cmd_io0_we", flash_io0_we, 1);
    wait_valid(300, n);
    chk("w0_latency", n, 128);
    chk("w0_data", qspi_readData, 32'h44332211);
    chk("w0_cmd", m_cmd, 32'h03000100);
    @(negedge clk);
    chk("w0_pulse_width", qspi_readDataValid, 0);
    chk("hold_csb", flash_csb, 0);
    chk("hold_busy", qspi_busy, 0);
    chk("hold_io0_we", flash_io0_we, 0);

    // Sequential words from HOLD: no command phase, 64 cycles each.
    falls0 = m_csb_falls;
    qspi_requestData = 1'b1;
    @(negedge clk);
    qspi_requestData = 1'b0;
    wait_valid(300, n);
    chk("w1_latency", n, 64);
    chk("w1_data", qspi_readData, 32'h40372615);
    qspi_requestData = 1'b1;
    @(negedge clk);
    qspi_requestData = 1'b0;
    wait_valid(300, n);
    chk("w2_latency", n, 64);
    chk("w2_data", qspi_readData, 32'h4C3B2A19);
    qspi_requestData = 1'b1;
    @(negedge clk);
    qspi_requestData = 1'b0;
    wait_valid(300, n);
    chk("w3_latency", n, 64);
    chk("w3_data", qspi_readData, 32'h483F2E1D);
    chk("stream_no_csb_fall", m_csb_falls - falls0, 0);

    // New address from HOLD near the top of the space; the next word wraps to 0.
    qspi_address = 24'hFFFFFC;
    qspi_changeAddress = 1'b1;
    @(negedge clk);
    qspi_changeAddress = 1'b0;
    n = 0;
    while (flash_csb == 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("regap_len", n, 4);
    wait_valid(300, n);
    chk("w4_latency", n, 128);
    chk("w4_cmd", m_cmd, 32'h03FFFFFC);
    chk("w4_data", qspi_readData, 32'h47302112);
    qspi_requestData = 1'b1;
    @(negedge clk);
    qspi_requestData = 1'b0;
    wait_valid(300, n);
    chk("w5_latency", n, 64);
    chk("w5_wrap_data", qspi_readData, 32'h44332211);

    // Enable dropped mid-READ: CSB high next cycle, word discarded.
    qspi_requestData = 1'b1;
    @(negedge clk);
    qspi_requestData = 1'b0;
    repeat (20) @(negedge clk);
    qspi_enable = 1'b0;
    @(negedge clk);
    chk("abort_csb", flash_csb, 1);
    chk("abort_sck", flash_sck, 0);
    chk("abort_busy", qspi_busy, 0);
    repeat (2) @(negedge clk);
    qspi_enable = 1'b1;
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (qspi_readDataValid) pulses++;
    end
    chk("abort_no_valid", pulses, 0);
    chk("abort_data_kept", qspi_readData, 32'h44332211);

    // requestData alone in IDLE is rejected.
    falls0 = m_csb_falls;
    qspi_requestData = 1'b1;
    @(negedge clk);
    qspi_requestData = 1'b0;
    chk("idle_req_busy", qspi_busy, 0);
    repeat (50) @(negedge clk);
    chk("idle_req_no_txn", m_csb_falls - falls0, 0);
    chk("idle_req_csb", flash_csb, 1);

    // Asynchronous reset in the middle of COMMAND, then a full restart.
    qspi_address = 24'h000200;
    qspi_changeAddress = 1'b1;
    @(negedge clk);
    qspi_changeAddress = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_csb_low", flash_csb, 0);
    falls0 = m_csb_falls;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_csb", flash_csb, 1);
    chk("arst_sck", flash_sck, 0);
    chk("arst_init", qspi_initialised, 0);
    chk("arst_busy", qspi_busy, 1);
    chk("arst_data", qspi_readData, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!qspi_initialised && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("restart_init_cycles", n, 144);
    chk("restart_wake_once", m_csb_falls - falls0, 1);
    chk("restart_wake_cmd", {24'h0, m_cmd[7:0]}, 32'hAB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
